led_sequencer: RTL and testbench

Parametrised LED pattern sequencer for the disco LED board. Drives an N_LED-wide bank from one clock, stepping one pattern frame per rate tick. Offers four selectable patterns, runtime speed selection, direction control, pause, and step/wrap status pulses. It sits between the board switches and the LED pins, and replaces the fixed 16-LED rotate-only design.

---
 rtl/led_seq_pkg.sv | 29 ++
 rtl/rate_tick.sv | 51 +++++
 rtl/led_sequencer.sv | 179 +++++++++++++++++
 tb/tb_led_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and elaboration-time helpers for the LED sequencer.
//   mode_t      : pattern select encoding (matches the 2-bit mode input)
//   rate_thresh : clock cycles per frame step for speed select s
//   alt_pattern : alternating bit pattern with bit 0 set, n bits wide
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_ALT    = 2'b11
    } mode_t;

    // Upper bound on the LED bank width handled by alt_pattern.
    localparam int unsigned MAX_LED = 256;

    function automatic int unsigned rate_thresh(input int unsigned clk_hz, input int unsigned s);
        return clk_hz / (s + 1);
    endfunction

    function automatic logic [MAX_LED-1:0] alt_pattern(input int unsigned n);
        logic [MAX_LED-1:0] r;
        for (int unsigned i = 0; i < MAX_LED; i++) begin
            r[i] = (i < n) && (i % 2 == 0);
        end
        return r;
    endfunction

endpackage

// File: rtl/rate_tick.sv
// Frame-rate prescaler: produces a one-cycle registered tick every
// rate_thresh(CLK_HZ, speed) cycles. Speed changes apply immediately.
// While paused the count holds and no tick is produced.
//   clk, rst : clock, async active-high reset
//   speed    : rate select, step rate = speed+1 Hz
//   pause    : hold counter, suppress tick
//   tick     : registered one-cycle step request
module rate_tick
    import led_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned SPD_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SPD_W-1:0] speed,
    input  logic             pause,
    output logic             tick
);

    localparam int unsigned N_RATE = 2 ** SPD_W;
    localparam int unsigned CNT_W  = $clog2(CLK_HZ);

    logic [CNT_W-1:0] thresh [N_RATE];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thr;

    // Terminal count per speed, folded to constants at elaboration.
    for (genvar g = 0; g < N_RATE; g++) begin : g_thresh
        assign thresh[g] = CNT_W'(rate_thresh(CLK_HZ, g) - 1);
    end

    assign thr = thresh[speed];

    // A count already past a newly selected threshold fires on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (pause) begin
            tick <= 1'b0;
        end else if (cnt >= thr) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: steps one frame of the selected pattern per rate
// tick. Patterns: ROTATE, BOUNCE, FILL, ALT. A mode change restarts the
// pattern at its start frame without a step or wrap pulse.
// Build option: define LED_SEQ_BOUNCE_EN to implement BOUNCE; otherwise
// mode 01 decodes as ROTATE.
//   clk, rst   : clock, async active-high reset
//   speed      : rate select, step rate = speed+1 Hz
//   mode       : 00 ROTATE, 01 BOUNCE, 10 FILL, 11 ALT
//   direction  : 1 toward MSB / fill from LSB, 0 toward LSB / fill from MSB
//   pause      : freeze rate counter and pattern
//   led        : registered LED drive
//   step_pulse : one-cycle pulse per frame advance
//   wrap       : one-cycle pulse when a pattern period completes
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned N_LED  = 16,
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned SPD_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SPD_W-1:0] speed,
    input  logic [1:0]       mode,
    input  logic             direction,
    input  logic             pause,
    output logic [N_LED-1:0] led,
    output logic             step_pulse,
    output logic             wrap
);

    localparam int unsigned        POS_W    = $clog2(N_LED + 1);
    localparam logic [MAX_LED-1:0] ALT_FULL = alt_pattern(N_LED);
    localparam logic [N_LED-1:0]   ALT0     = ALT_FULL[N_LED-1:0];
    localparam logic [POS_W-1:0]   P_FULL   = POS_W'(N_LED);
    localparam logic [POS_W-1:0]   P_LAST   = POS_W'(N_LED - 1);
`ifdef LED_SEQ_BOUNCE_EN
    localparam logic [POS_W-1:0]   P_PRE    = POS_W'(N_LED - 2);
`endif

    logic             tick;
    mode_t            mode_dec;
    mode_t            mode_q,  mode_n;
    logic [POS_W-1:0] pos,     pos_n;
    logic             up,      up_n;
    logic             phase,   phase_n;
    logic [N_LED-1:0] led_n;
    logic             step_n;
    logic             wrap_n;

    rate_tick #(
        .CLK_HZ (CLK_HZ),
        .SPD_W  (SPD_W)
    ) u_rate_tick (
        .clk   (clk),
        .rst   (rst),
        .speed (speed),
        .pause (pause),
        .tick  (tick)
    );

    // Mode decode; without BOUNCE support mode 01 aliases ROTATE.
    always_comb begin
`ifdef LED_SEQ_BOUNCE_EN
        mode_dec = mode_t'(mode);
`else
        mode_dec = (mode == 2'b01) ? MODE_ROTATE : mode_t'(mode);
`endif
    end

    // LED frame for a given state; pos is the fill level in FILL mode.
    function automatic logic [N_LED-1:0] frame(input mode_t m, input logic [POS_W-1:0] p,
                                               input logic ph, input logic dir);
        logic [N_LED-1:0] f;
        f = '0;
        case (m)
            MODE_FILL: begin
                for (int unsigned i = 0; i < N_LED; i++) begin
                    f[i] = dir ? (i < 32'(p)) : (i + 32'(p) >= N_LED);
                end
            end
            MODE_ALT: f = ph ? ~ALT0 : ALT0;
            default: begin
                for (int unsigned i = 0; i < N_LED; i++) begin
                    f[i] = (i == 32'(p));
                end
            end
        endcase
        return f;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_ROTATE;
            pos        <= '0;
            up         <= 1'b1;
            phase      <= 1'b0;
            led        <= N_LED'(1);
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            mode_q     <= mode_n;
            pos        <= pos_n;
            up         <= up_n;
            phase      <= phase_n;
            led        <= led_n;
            step_pulse <= step_n;
            wrap       <= wrap_n;
        end
    end

    // Next-state: restart on mode change (discarding any tick), else step on tick.
    always_comb begin
        mode_n  = mode_q;
        pos_n   = pos;
        up_n    = up;
        phase_n = phase;
        led_n   = led;
        step_n  = 1'b0;
        wrap_n  = 1'b0;
        if (mode_dec != mode_q) begin
            mode_n  = mode_dec;
            pos_n   = (mode_dec == MODE_FILL) ? POS_W'(1) : '0;
            up_n    = 1'b1;
            phase_n = 1'b0;
            led_n   = frame(mode_dec, pos_n, 1'b0, direction);
        end else if (tick && !pause) begin
            step_n = 1'b1;
            case (mode_q)
`ifdef LED_SEQ_BOUNCE_EN
                MODE_BOUNCE: begin
                    if (up && pos == P_LAST) begin
                        pos_n = P_PRE;
                        up_n  = 1'b0;
                    end else if (up) begin
                        pos_n = pos + POS_W'(1);
                    end else begin
                        pos_n = pos - POS_W'(1);
                    end
                    // Landing on 0 while descending closes the period.
                    if (!up_n && pos_n == '0) begin
                        up_n   = 1'b1;
                        wrap_n = 1'b1;
                    end
                end
`endif
                MODE_FILL: begin
                    if (up && pos == P_FULL) begin
                        pos_n = P_LAST;
                        up_n  = 1'b0;
                    end else if (up) begin
                        pos_n = pos + POS_W'(1);
                    end else begin
                        pos_n = pos - POS_W'(1);
                    end
                    if (!up_n && pos_n == '0) begin
                        up_n   = 1'b1;
                        wrap_n = 1'b1;
                    end
                end
                MODE_ALT: begin
                    phase_n = ~phase;
                    wrap_n  = phase;
                end
                default: begin
                    if (direction) begin
                        pos_n = (pos == P_LAST) ? '0 : pos + POS_W'(1);
                    end else begin
                        pos_n = (pos == '0) ? P_LAST : pos - POS_W'(1);
                    end
                    wrap_n = (pos_n == '0);
                end
            endcase
            led_n = frame(mode_q, pos_n, phase_n, direction);
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (CLK_HZ=8, SPD_W=2, N_LED=8).
// Reference model tracks each pattern as an index into its period.
module tb_led_sequencer;

    localparam int N = 8;
    localparam int HZ = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic [1:0] mode;
    logic       direction;
    logic       pause;
    logic [7:0] led;
    logic       step_pulse;
    logic       wrap;

    int checks = 0;
    int failures = 0;

    int m_cnt, m_tick, m_mode, m_k, m_pos;
    logic [7:0] e_led;
    logic e_sp, e_wr;

    led_sequencer #(.N_LED(N), .CLK_HZ(HZ), .SPD_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .speed      (speed),
        .mode       (mode),
        .direction  (direction),
        .pause      (pause),
        .led        (led),
        .step_pulse (step_pulse),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dec_mode(input int m);
`ifdef LED_SEQ_BOUNCE_EN
        return m;
`else
        return (m == 1) ? 0 : m;
`endif
    endfunction

    function automatic int period(input int m);
        case (m)
            1: return 2 * N - 2;
            2: return 2 * N;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] exp_frame(input int m, input int k, input int p, input logic dir);
        int idx, lvl, v;
        case (m)
            0: return 8'(1 << p);
            1: begin
                idx = (k < N) ? k : 2 * N - 2 - k;
                return 8'(1 << idx);
            end
            2: begin
                lvl = (k < N) ? k + 1 : 2 * N - 1 - k;
                v = (1 << lvl) - 1;
                return dir ? 8'(v) : 8'(v << (N - lvl));
            end
            default: return (k % 2 == 1) ? 8'hAA : 8'h55;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_tick = 0; m_mode = 0; m_k = 0; m_pos = 0;
        e_led = 8'h01; e_sp = 1'b0; e_wr = 1'b0;
    endtask

    // One clock edge of reference behaviour using the inputs present at that edge.
    task automatic model_edge();
        int old_t, dm, t;
        if (rst) return;
        old_t = m_tick;
        t = HZ / (int'(speed) + 1);
        if (pause) m_tick = 0;
        else if (m_cnt >= t - 1) begin m_cnt = 0; m_tick = 1; end
        else begin m_cnt++; m_tick = 0; end
        dm = dec_mode(int'(mode));
        if (dm != m_mode) begin
            m_mode = dm; m_k = 0; m_pos = 0;
            e_led = exp_frame(m_mode, 0, 0, direction);
            e_sp = 1'b0; e_wr = 1'b0;
        end else if (old_t == 1 && !pause) begin
            e_sp = 1'b1;
            if (m_mode == 0) begin
                m_pos = direction ? (m_pos + 1) % N : (m_pos + N - 1) % N;
                e_wr = (m_pos == 0);
            end else begin
                m_k = (m_k + 1) % period(m_mode);
                e_wr = (m_mode == 2) ? (m_k == 2 * N - 1) : (m_k == 0);
            end
            e_led = exp_frame(m_mode, m_k, m_pos, direction);
        end else begin
            e_sp = 1'b0; e_wr = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check("led", 32'(led), 32'(e_led));
            check("step_pulse", 32'(step_pulse), 32'(e_sp));
            check("wrap", 32'(wrap), 32'(e_wr));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; speed = 2'd0; mode = 2'd0; direction = 1'b1; pause = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_led", 32'(led), 32'h01);
        check("reset_step", 32'(step_pulse), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        rst = 1'b0;

        // First step lands on edge 9 after release at speed 0.
        n = 0;
        for (int i = 0; i < 20; i++) begin
            run(1);
            n++;
            if (step_pulse) break;
        end
        check("first_step_edge", 32'(n), 32'd9);
        check("first_step_led", 32'(led), 32'h02);
        run(70);

        speed = 2'd1; run(40);
        speed = 2'd2; run(30);
        speed = 2'd3; run(30);

        // Speed 0 -> 3 while count is 5: tick on the very next edge.
        speed = 2'd0;
        for (int i = 0; i < 20 && m_cnt != 5; i++) run(1);
        check("cnt5_reached", 32'(m_cnt), 32'd5);
        speed = 2'd3; run(6);

        mode = 2'd1; run(70);
        mode = 2'd2; direction = 1'b1; run(70);
        direction = 1'b0; run(70);
        mode = 2'd3; run(20);

        // Mode change in the tick-high cycle: start frame, no step.
        for (int i = 0; i < 20 && m_tick != 1; i++) run(1);
        check("tick_seen", 32'(m_tick), 32'd1);
        mode = 2'd2; direction = 1'b1;
        run(1);
        check("restart_led", 32'(led), 32'h01);
        check("restart_step", 32'(step_pulse), 32'd0);
        run(10);

        // Pause for 20 cycles mid-count, then resume.
        speed = 2'd0;
        for (int i = 0; i < 20 && m_cnt != 3; i++) run(1);
        pause = 1'b1; run(20);
        pause = 1'b0; run(12);

        // Asynchronous reset mid-FILL.
        mode = 2'd2; run(15);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", 32'(led), 32'h01);
        check("async_rst_step", 32'(step_pulse), 32'd0);
        check("async_rst_wrap", 32'(wrap), 32'd0);
        model_reset();
        run(2);
        rst = 1'b0;
        run(20);

        // Randomized input churn.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(29) == 0) speed = 2'($urandom_range(3));
            if ($urandom_range(24) == 0) direction = ~direction;
            if ($urandom_range(49) == 0) pause = ~pause;
            run(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
